// File: rtl/candidate_selector.sv
// Collects candidate reads for one read, keeps the first non-original candidate,
// and emits a corrected read plus status (solid/corrected/uncorrectable/ambiguous).
module candidate_selector #(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_READ_WIDTH     = 1 << MAX_READ_BIT_WIDTH,
    parameter int COUNT_WIDTH        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*MAX_READ_WIDTH-1:0] originalRead,
    input  logic [2*MAX_READ_WIDTH-1:0] candidate,
    input  logic                        candidateValid,
    input  logic                        readDone,
    output logic                        ready4Candidate,
    output logic [2*MAX_READ_WIDTH-1:0] correctedRead,
    output logic [1:0]                  correctionStatus,
    output logic [COUNT_WIDTH-1:0]      candidateCount,
    output logic                        correctedValid,
    input  logic                        outReady,
    output logic                        protocolError
);
    localparam int RW = 2 * MAX_READ_WIDTH;

    localparam logic [1:0] ST_SOLID     = 2'b00;
    localparam logic [1:0] ST_CORRECTED = 2'b01;
    localparam logic [1:0] ST_UNCORR    = 2'b10;
    localparam logic [1:0] ST_AMBIG     = 2'b11;

    typedef enum logic [1:0] {COLLECT, DECIDE, OUTPUT} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   solid_q, solid_d;
    logic [RW-1:0]          first_q, first_d;
    logic [RW-1:0]          read_out_q, read_out_d;
    logic [1:0]             status_q, status_d;
    logic [COUNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
    logic                   perr_q, perr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            solid_q    <= 1'b0;
            first_q    <= '0;
            read_out_q <= '0;
            status_q   <= ST_SOLID;
            cnt_out_q  <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            solid_q    <= solid_d;
            first_q    <= first_d;
            read_out_q <= read_out_d;
            status_q   <= status_d;
            cnt_out_q  <= cnt_out_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        solid_d    = solid_q;
        first_d    = first_q;
        read_out_d = read_out_q;
        status_d   = status_q;
        cnt_out_d  = cnt_out_q;
        perr_d     = perr_q;

        // Inputs outside COLLECT are dropped and flagged.
        if (state_q != COLLECT && (candidateValid || readDone))
            perr_d = 1'b1;

        case (state_q)
            COLLECT: begin
                if (candidateValid) begin
                    if (candidate == originalRead) begin
                        solid_d = 1'b1;
                    end else begin
                        if (count_q == '0)
                            first_d = candidate;
                        if (count_q != {COUNT_WIDTH{1'b1}})
                            count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
                if (readDone)
                    state_d = DECIDE;
            end
            DECIDE: begin
                cnt_out_d = count_q;
                if (solid_q) begin
                    status_d   = ST_SOLID;
                    read_out_d = originalRead;
                end else if (count_q == '0) begin
                    status_d   = ST_UNCORR;
                    read_out_d = originalRead;
                end else if (count_q == COUNT_WIDTH'(1)) begin
                    status_d   = ST_CORRECTED;
                    read_out_d = first_q;
                end else begin
                    status_d   = ST_AMBIG;
                    read_out_d = originalRead;
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (outReady) begin
                    count_d = '0;
                    solid_d = 1'b0;
                    first_d = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign ready4Candidate  = (state_q == COLLECT);
    assign correctedValid   = (state_q == OUTPUT);
    assign correctedRead    = read_out_q;
    assign correctionStatus = status_q;
    assign candidateCount   = cnt_out_q;
    assign protocolError    = perr_q;

endmodule

// File: doc/candidate_selector.md
Name: candidate_selector

Overview:
- Sits directly downstream of the substitution k-mer generator. Consumes the candidate reads that generator emits for one read, counts them, and keeps the first one.
- When the read finishes, it decides the outcome: solid, uniquely corrected, uncorrectable or ambiguous.
- It then emits one corrected read plus a status code to the write-back stage over a valid/ready handshake.

Parameters:
- MAX_READ_BIT_WIDTH, 8, log2 of the maximum read length in bases.
- MAX_READ_WIDTH, 256, maximum read length in bases (1 << MAX_READ_BIT_WIDTH).
- COUNT_WIDTH, 4, width of the saturating candidate counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- originalRead  in  2*MAX_READ_WIDTH  read currently under correction; stable from first candidate to readDone.
- candidate  in  2*MAX_READ_WIDTH  candidate read from the upstream stage.
- candidateValid  in  1  candidate is valid this cycle.
- readDone  in  1  one-cycle pulse: all candidates for the current read have been delivered.
- ready4Candidate  out  1  block accepts candidates and readDone.
- correctedRead  out  2*MAX_READ_WIDTH  selected output read.
- correctionStatus  out  2  00 solid, 01 corrected, 10 uncorrectable, 11 ambiguous.
- candidateCount  out  COUNT_WIDTH  number of non-original candidates seen (saturating).
- correctedValid  out  1  output valid.
- outReady  in  1  downstream accepts the output.
- protocolError  out  1  sticky: readDone or candidateValid arrived while ready4Candidate was low.

Behaviour:
- Reset (async, any state): state COLLECT, all counters/flags/stored read cleared, correctedValid=0, correctedRead=0, correctionStatus=00, candidateCount=0, protocolError=0. ready4Candidate=1 immediately after reset deasserts.
- States: COLLECT -> DECIDE -> OUTPUT -> COLLECT.
- COLLECT:
  - ready4Candidate=1.
  - A candidate is accepted on candidateValid & ready4Candidate.
  - If candidate == originalRead (full-width compare), set originalSolid; it is not counted.
  - Otherwise, if count==0, store candidate into firstCand. Then count increments, saturating at 2^COUNT_WIDTH-1 (no wrap).
  - readDone moves to DECIDE. A candidate arriving in the same cycle as readDone is processed before the decision.
- DECIDE: one cycle, ready4Candidate=0. Registers the result:
  - originalSolid=1 -> status 00, correctedRead=originalRead. Solid takes priority over any count.
  - else count==0 -> status 10, correctedRead=originalRead.
  - else count==1 -> status 01, correctedRead=firstCand.
  - else count>=2 -> status 11, correctedRead=originalRead.
  - candidateCount is registered with the count.
  - Next state is OUTPUT.
- OUTPUT:
  - correctedValid=1. correctedRead, status and count are held stable until accepted.
  - On correctedValid & outReady: next cycle correctedValid=0; count, originalSolid and firstCand are cleared; state returns to COLLECT.
- Latency: readDone at cycle t -> correctedValid high at t+2 (at the earliest). Minimum read-to-read turnaround is 3 cycles (outReady tied high).
- protocolError:
  - Set when candidateValid or readDone is high while ready4Candidate=0.
  - The offending input is ignored.
  - Cleared only by reset.
- Reset mid-OUTPUT drops the pending result; no partial output is ever produced.
- correctedRead/status/candidateCount outside OUTPUT hold their last accepted values (0 after reset).

Test Plan:
1. Read R; candidates: R only, then readDone -> at t+2 correctedValid=1, status=00, correctedRead=R, candidateCount=0.
2. One candidate C!=R, then readDone, outReady=1 -> status=01, correctedRead=C, candidateCount=1; correctedValid is high for exactly 1 cycle; ready4Candidate returns high the next cycle.
3. Candidates C1, C2, C3 (all !=R), readDone in the same cycle as C3 -> status=11, correctedRead=R, candidateCount=3.
4. No candidates, readDone; outReady low for 5 cycles, then high -> status=10, correctedRead=R; correctedValid is held for 6 cycles with outputs stable.
5. 20 distinct candidates with COUNT_WIDTH=4 -> candidateCount=15 (saturated, no wrap), status=11. Then candidateValid pulsed during OUTPUT -> protocolError=1, result unchanged.
6. Assert rst during OUTPUT -> correctedValid=0 immediately, ready4Candidate=1 after release. Next read with a single candidate C -> status=01, correctedRead=C, candidateCount=1.
